// File: rtl/hazard_if.sv
// Hazard-controller signal bundle: decoded hazard inputs from the pipeline and
// the stall/flush/enable controls plus performance counters returned to it.
interface hazard_if #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic                  id_is_jump;
  logic                  ex_is_load;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  mem_is_branch;
  logic                  mem_branch_taken;
  logic                  pipe_hold;
  logic                  cnt_clear;

  logic                  stall_pipeline;
  logic                  pc_write_enable;
  logic                  if_id_write_enable;
  logic                  id_ex_write_enable;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  ex_mem_flush;
  logic                  pc_sel_branch;
  logic                  pc_sel_jump;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_jump, ex_is_load, ex_rt,
           mem_is_branch, mem_branch_taken, pipe_hold, cnt_clear,
    input  stall_pipeline, pc_write_enable, if_id_write_enable, id_ex_write_enable,
           if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_branch, pc_sel_jump,
           stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_jump, ex_is_load, ex_rt,
           mem_is_branch, mem_branch_taken, pipe_hold, cnt_clear,
    output stall_pipeline, pc_write_enable, if_id_write_enable, id_ex_write_enable,
           if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_branch, pc_sel_jump,
           stall_count, flush_count
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard controller for the core_lapido 5-stage pipeline: load-use stalls, branch
// and jump flushes, external hold, and saturating stall/flush event counters.
module hazard_control_unit #(
  parameter int REG_ADDR_W        = 4,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);

  typedef enum logic {S_RUN, S_LDSTALL} state_t;

  localparam logic [2:0] STALL_EXTRA = 3'(LOAD_STALL_CYCLES - 1);

  state_t           state, state_nxt;
  logic [2:0]       rem, rem_nxt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             load_use, branch_taken, stall_evt, flush_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Register 0 is deliberately not special-cased: loads to r0 still stall.
  assign load_use = hz.ex_is_load &
                    ((hz.id_uses_rs & (hz.id_rs == hz.ex_rt)) |
                     (hz.id_uses_rt & (hz.id_rt == hz.ex_rt)));
  assign branch_taken = hz.mem_is_branch & hz.mem_branch_taken;

  always_comb begin
    hz.stall_pipeline     = 1'b0;
    hz.pc_write_enable    = 1'b0;
    hz.if_id_write_enable = 1'b0;
    hz.id_ex_write_enable = 1'b0;
    hz.if_id_flush        = 1'b0;
    hz.id_ex_flush        = 1'b0;
    hz.ex_mem_flush       = 1'b0;
    hz.pc_sel_branch      = 1'b0;
    hz.pc_sel_jump        = 1'b0;
    state_nxt             = state;
    rem_nxt               = rem;
    stall_evt             = 1'b0;
    flush_evt             = 1'b0;

    if (!rst_n) begin
      hz.stall_pipeline = 1'b1;
    end else if (hz.pipe_hold) begin
      state_nxt = state;
    end else if (branch_taken) begin
      hz.pc_write_enable    = 1'b1;
      hz.if_id_write_enable = 1'b1;
      hz.id_ex_write_enable = 1'b1;
      hz.if_id_flush        = 1'b1;
      hz.id_ex_flush        = 1'b1;
      hz.ex_mem_flush       = 1'b1;
      hz.pc_sel_branch      = 1'b1;
      state_nxt             = S_RUN;
      rem_nxt               = 3'd0;
      flush_evt             = 1'b1;
    end else if ((state == S_LDSTALL) || load_use) begin
      // The bubble is written into ID/EX while PC and IF/ID hold the consumer.
      hz.stall_pipeline     = 1'b1;
      hz.id_ex_write_enable = 1'b1;
      stall_evt             = 1'b1;
      if (state == S_LDSTALL) begin
        rem_nxt = 3'(rem - 3'd1);
        if (rem == 3'd1) state_nxt = S_RUN;
      end else if (LOAD_STALL_CYCLES > 1) begin
        state_nxt = S_LDSTALL;
        rem_nxt   = STALL_EXTRA;
      end
    end else if (hz.id_is_jump) begin
      hz.pc_write_enable    = 1'b1;
      hz.if_id_write_enable = 1'b1;
      hz.id_ex_write_enable = 1'b1;
      hz.if_id_flush        = 1'b1;
      hz.pc_sel_jump        = 1'b1;
      flush_evt             = 1'b1;
    end else begin
      hz.pc_write_enable    = 1'b1;
      hz.if_id_write_enable = 1'b1;
      hz.id_ex_write_enable = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RUN;
      rem   <= 3'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Clear wins over a same-cycle increment; hold freezes counters via the events.
  always_ff @(posedge clk) begin
    if (!rst_n || hz.cnt_clear) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt) stall_cnt <= sat_inc(stall_cnt);
      if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign hz.stall_count = stall_cnt;
  assign hz.flush_count = flush_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized bench for hazard_control_unit: two instances (1-cycle and 3-cycle
// load stalls, 4-bit counters on the latter) checked against a behavioural model.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, id_is_jump, ex_is_load;
  logic       mem_is_branch, mem_branch_taken, pipe_hold, cnt_clear;

  hazard_if #(.REG_ADDR_W(4), .CNT_W(16)) hz1 ();
  hazard_if #(.REG_ADDR_W(4), .CNT_W(4))  hz3 ();

  assign hz1.id_rs = id_rs;               assign hz3.id_rs = id_rs;
  assign hz1.id_rt = id_rt;               assign hz3.id_rt = id_rt;
  assign hz1.ex_rt = ex_rt;               assign hz3.ex_rt = ex_rt;
  assign hz1.id_uses_rs = id_uses_rs;     assign hz3.id_uses_rs = id_uses_rs;
  assign hz1.id_uses_rt = id_uses_rt;     assign hz3.id_uses_rt = id_uses_rt;
  assign hz1.id_is_jump = id_is_jump;     assign hz3.id_is_jump = id_is_jump;
  assign hz1.ex_is_load = ex_is_load;     assign hz3.ex_is_load = ex_is_load;
  assign hz1.mem_is_branch = mem_is_branch;       assign hz3.mem_is_branch = mem_is_branch;
  assign hz1.mem_branch_taken = mem_branch_taken; assign hz3.mem_branch_taken = mem_branch_taken;
  assign hz1.pipe_hold = pipe_hold;       assign hz3.pipe_hold = pipe_hold;
  assign hz1.cnt_clear = cnt_clear;       assign hz3.cnt_clear = cnt_clear;

  hazard_control_unit #(.REG_ADDR_W(4), .LOAD_STALL_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .hz(hz1));
  hazard_control_unit #(.REG_ADDR_W(4), .LOAD_STALL_CYCLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .hz(hz3));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Model: stall cycles still owed, counter values; index 0 = dut1, 1 = dut3.
  int m_left[2] = '{0, 0};
  int m_sc[2]   = '{0, 0};
  int m_fc[2]   = '{0, 0};
  int lsc[2]    = '{1, 3};
  int cmax[2]   = '{65535, 15};

  // {stall, pc_we, if_id_we, id_ex_we, if_id_fl, id_ex_fl, ex_mem_fl, sel_br, sel_j}
  function automatic logic [8:0] exp_ctl(input int left, input bit rstn, input bit hold,
                                         input bit brt, input bit lu, input bit jmp);
    if (!rstn)            return 9'b100000000;
    if (hold)             return 9'b000000000;
    if (brt)              return 9'b011111110;
    if (left > 0 || lu)   return 9'b100100000;
    if (jmp)              return 9'b011110001;
    return 9'b011100000;
  endfunction

  function automatic logic [8:0] obs1();
    return {hz1.stall_pipeline, hz1.pc_write_enable, hz1.if_id_write_enable,
            hz1.id_ex_write_enable, hz1.if_id_flush, hz1.id_ex_flush, hz1.ex_mem_flush,
            hz1.pc_sel_branch, hz1.pc_sel_jump};
  endfunction

  function automatic logic [8:0] obs3();
    return {hz3.stall_pipeline, hz3.pc_write_enable, hz3.if_id_write_enable,
            hz3.id_ex_write_enable, hz3.if_id_flush, hz3.id_ex_flush, hz3.ex_mem_flush,
            hz3.pc_sel_branch, hz3.pc_sel_jump};
  endfunction

  task automatic step();
    bit lu, brt, is_stall, is_flush;
    logic [8:0] e;
    lu  = ex_is_load && ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    brt = mem_is_branch && mem_branch_taken;
    #4;
    for (int k = 0; k < 2; k++) begin
      e = exp_ctl(m_left[k], rst_n, pipe_hold, brt, lu, id_is_jump);
      if (k == 0) begin
        check("ctl_l1", {23'b0, obs1()}, {23'b0, e});
        check("stall_cnt_l1", {16'b0, hz1.stall_count}, m_sc[0]);
        check("flush_cnt_l1", {16'b0, hz1.flush_count}, m_fc[0]);
      end else begin
        check("ctl_l3", {23'b0, obs3()}, {23'b0, e});
        check("stall_cnt_l3", {28'b0, hz3.stall_count}, m_sc[1]);
        check("flush_cnt_l3", {28'b0, hz3.flush_count}, m_fc[1]);
      end
      if (!rst_n) begin
        m_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end else begin
        is_stall = 0; is_flush = 0;
        if (!pipe_hold) begin
          if (brt) begin
            m_left[k] = 0; is_flush = 1;
          end else if (m_left[k] > 0 || lu) begin
            is_stall = 1;
            m_left[k] = (m_left[k] > 0) ? m_left[k] - 1 : lsc[k] - 1;
          end else if (id_is_jump) begin
            is_flush = 1;
          end
        end
        if (cnt_clear) begin
          m_sc[k] = 0; m_fc[k] = 0;
        end else begin
          if (is_stall && m_sc[k] < cmax[k]) m_sc[k]++;
          if (is_flush && m_fc[k] < cmax[k]) m_fc[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; id_rs = 4'd0; id_rt = 4'd0; ex_rt = 4'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_jump = 1'b0; ex_is_load = 1'b0;
    mem_is_branch = 1'b0; mem_branch_taken = 1'b0; pipe_hold = 1'b0; cnt_clear = 1'b0;
  endtask

  task automatic hazard_rt3();
    ex_is_load = 1'b1; ex_rt = 4'd3; id_uses_rt = 1'b1; id_rt = 4'd3;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with a live hazard, then released
    ex_is_load = 1'b1; id_rs = 4'd5; ex_rt = 4'd5; id_uses_rs = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    idle();
    repeat (4) step();

    // Single load-use pulse, then same without rt use
    hazard_rt3();
    step();
    idle();
    repeat (4) step();
    hazard_rt3(); id_uses_rt = 1'b0;
    step();
    idle();
    step();

    // Taken branch in the second stall cycle
    hazard_rt3();
    step();
    idle();
    mem_is_branch = 1'b1; mem_branch_taken = 1'b1;
    step();
    idle();
    repeat (3) step();

    // Jump waiting behind a load-use on rs=15
    id_is_jump = 1'b1; ex_is_load = 1'b1; ex_rt = 4'd15; id_rs = 4'd15; id_uses_rs = 1'b1;
    step();
    ex_is_load = 1'b0;
    repeat (3) step();
    idle();
    step();

    // Hold during a multi-cycle stall
    hazard_rt3();
    step();
    idle();
    pipe_hold = 1'b1;
    repeat (4) step();
    pipe_hold = 1'b0;
    repeat (4) step();

    // Drive counters into saturation, then clear
    hazard_rt3();
    repeat (20) step();
    idle();
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    repeat (2) step();

    // Randomized traffic
    repeat (3000) begin
      rst_n            = ($urandom_range(0, 63) != 0);
      pipe_hold        = ($urandom_range(0, 7) == 0);
      id_rs            = 4'($urandom_range(0, 3));
      id_rt            = 4'($urandom_range(0, 3));
      ex_rt            = 4'($urandom_range(0, 3));
      id_uses_rs       = ($urandom_range(0, 1) == 1);
      id_uses_rt       = ($urandom_range(0, 1) == 1);
      ex_is_load       = ($urandom_range(0, 2) == 0);
      id_is_jump       = ($urandom_range(0, 3) == 0);
      mem_is_branch    = ($urandom_range(0, 5) == 0);
      mem_branch_taken = ($urandom_range(0, 1) == 1);
      cnt_clear        = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
